// File: rtl/dmem_ctrl_if.sv
// Bundle of the CPU-side request/response signals and the data-memory port
// used by dmem_ctrl. The master side is the CPU datapath plus the memory.
interface dmem_ctrl_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        addr_err;
   logic        CS;
   logic        DM_R;
   logic        DM_W;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      output req, we, size, sign_ext, addr, wdata, mem_rdata,
      input  rdata, busy, done, addr_err, CS, DM_R, DM_W, mem_addr, mem_wdata
   );

   modport slave (
      input  req, we, size, sign_ext, addr, wdata, mem_rdata,
      output rdata, busy, done, addr_err, CS, DM_R, DM_W, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte/halfword/word load-store controller for a word-only data memory.
// Sub-word stores run as read-modify-write; misaligned requests never reach memory.
module dmem_ctrl #(
   parameter int ADDR_W = 8
) (
   input logic        clk,
   input logic        reset,
   dmem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_r;
   logic                we_r;
   logic [1:0]          size_r;
   logic                sign_ext_r;
   logic [ADDR_W+1:0]   addr_r;
   logic [31:0]         wdata_r;
   logic [31:0]         word_r;
   logic [31:0]         rdata_r;
   logic                busy_r;
   logic                done_r;
   logic                addr_err_r;
   logic                bad_s;
   logic [31:0]         word_addr_s;

   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
      case (sz)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = lo[0];
         2'b10:   misaligned = (lo != 2'b00);
         default: misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] format_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic sx, input logic [1:0] lo);
      logic [7:0]  b;
      logic [15:0] h;
      case (lo)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lo[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b00:   format_load = {{24{sx & b[7]}}, b};
         2'b01:   format_load = {{16{sx & h[15]}}, h};
         default: format_load = word;
      endcase
   endfunction

   // Replace only the addressed lane; a word store takes the store data whole.
   function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] sz, input logic [1:0] lo);
      merge_store = word;
      case (sz)
         2'b00: begin
            case (lo)
               2'b00:   merge_store[7:0]   = wd[7:0];
               2'b01:   merge_store[15:8]  = wd[7:0];
               2'b10:   merge_store[23:16] = wd[7:0];
               default: merge_store[31:24] = wd[7:0];
            endcase
         end
         2'b01: begin
            if (lo[1]) merge_store[31:16] = wd[15:0];
            else       merge_store[15:0]  = wd[15:0];
         end
         default: merge_store = wd;
      endcase
   endfunction

   assign bad_s       = misaligned(bus.size, bus.addr[1:0]);
   assign word_addr_s = {{(32-ADDR_W){1'b0}}, addr_r[ADDR_W+1:2]};

   assign bus.rdata    = rdata_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.addr_err = addr_err_r;

   // Memory strobes, address and write word decoded from the current state.
   always_comb begin
      bus.CS        = 1'b0;
      bus.DM_R      = 1'b0;
      bus.DM_W      = 1'b0;
      bus.mem_addr  = 32'h0000_0000;
      bus.mem_wdata = 32'h0000_0000;
      case (state_r)
         RD: begin
            bus.CS       = reset;
            bus.DM_R     = reset;
            bus.mem_addr = word_addr_s;
         end
         WR: begin
            bus.CS        = reset;
            bus.DM_W      = reset;
            bus.mem_addr  = word_addr_s;
            bus.mem_wdata = merge_store(word_r, wdata_r, size_r, addr_r[1:0]);
         end
         DONE:    bus.mem_addr = word_addr_s;
         default: bus.mem_addr = 32'h0000_0000;
      endcase
   end

   // Access sequencer with registered status and load data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         we_r       <= 1'b0;
         size_r     <= 2'b00;
         sign_ext_r <= 1'b0;
         addr_r     <= '0;
         wdata_r    <= 32'h0000_0000;
         word_r     <= 32'h0000_0000;
         rdata_r    <= 32'h0000_0000;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         addr_err_r <= 1'b0;
      end else begin
         done_r     <= 1'b0;
         addr_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.req) begin
                  we_r       <= bus.we;
                  size_r     <= bus.size;
                  sign_ext_r <= bus.sign_ext;
                  addr_r     <= bus.addr[ADDR_W+1:0];
                  wdata_r    <= bus.wdata;
                  busy_r     <= 1'b1;
                  if (bad_s) begin
                     state_r    <= DONE;
                     done_r     <= 1'b1;
                     addr_err_r <= 1'b1;
                  end else if (!bus.we || bus.size != 2'b10) begin
                     state_r <= RD;
                  end else begin
                     state_r <= WR;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            RD: begin
               word_r <= bus.mem_rdata;
               if (!we_r) begin
                  rdata_r <= format_load(bus.mem_rdata, size_r, sign_ext_r, addr_r[1:0]);
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= WR;
               end
            end
            WR: begin
               state_r <= DONE;
               done_r  <= 1'b1;
            end
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
